// File: rtl/gpio_disp_ctrl.sv
// GPIO-driven 8-digit seven-segment display controller with a switch synchronizer.
// Writes are decoded one nibble per cycle into shadow registers, then committed atomically.
module gpio_disp_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        blank_en,
    input  logic [17:0] sw_in,
    output logic [17:0] sw_sync,
    output logic        sw_changed,
    output logic [31:0] gpio_out,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StScan, StCommit} state_t;

    localparam logic [6:0] SegZero  = 7'h40;
    localparam logic [6:0] SegBlank = 7'h7F;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_data;
    logic        r_blank;
    logic [2:0]  r_idx;
    logic        r_lead;
    logic [6:0]  r_shadow [8];
    logic [6:0]  r_hex    [8];
    logic [31:0] r_gpio;
    logic        r_pend_vld;
    logic [31:0] r_pend_data;
    logic        r_pend_blank;

    logic        w_load;
    logic [31:0] w_load_data;
    logic        w_load_blank;
    logic [3:0]  w_nib;
    logic        w_zero_run;
    logic [6:0]  w_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    // A write arriving in the commit cycle is the newest, so it wins over any pending entry.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_data  = wr_data;
        w_load_blank = blank_en;
        unique case (r_state)
            StIdle: begin
                if (wr_en) begin
                    w_load      = 1'b1;
                    w_state_nxt = StScan;
                end
            end
            StScan: begin
                if (r_idx == 3'd0) w_state_nxt = StCommit;
            end
            StCommit: begin
                if (wr_en) begin
                    w_load      = 1'b1;
                    w_state_nxt = StScan;
                end else if (r_pend_vld) begin
                    w_load       = 1'b1;
                    w_load_data  = r_pend_data;
                    w_load_blank = r_pend_blank;
                    w_state_nxt  = StScan;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign w_nib      = r_data[{r_idx, 2'b00} +: 4];
    assign w_zero_run = r_lead && (w_nib == 4'h0);
    assign w_seg      = (r_blank && w_zero_run && (r_idx != 3'd0)) ? SegBlank : hex_glyph(w_nib);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_blank      <= 1'b0;
            r_idx        <= '0;
            r_lead       <= 1'b0;
            r_gpio       <= '0;
            r_pend_vld   <= 1'b0;
            r_pend_data  <= '0;
            r_pend_blank <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= SegZero;
                r_hex[i]    <= SegZero;
            end
        end else begin
            if (w_load) begin
                r_data  <= w_load_data;
                r_blank <= w_load_blank;
                r_idx   <= 3'd7;
                r_lead  <= 1'b1;
            end else if (r_state == StScan) begin
                r_shadow[r_idx] <= w_seg;
                r_idx           <= r_idx - 3'd1;
                r_lead          <= w_zero_run;
            end
            if (r_state == StCommit) begin
                r_gpio <= r_data;
                for (int i = 0; i < 8; i++) r_hex[i] <= r_shadow[i];
            end
            if (r_state == StCommit) begin
                r_pend_vld <= 1'b0;
            end else if (wr_en && (r_state == StScan)) begin
                r_pend_vld   <= 1'b1;
                r_pend_data  <= wr_data;
                r_pend_blank <= blank_en;
            end
        end
    end

    logic [17:0] r_sw_meta;
    logic [17:0] r_sw_sync;
    logic [17:0] r_sw_prev;
    logic        r_sw_chg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_sw_prev <= '0;
            r_sw_chg  <= 1'b0;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
            r_sw_prev <= r_sw_sync;
            r_sw_chg  <= (r_sw_sync != r_sw_prev);
        end
    end

    assign sw_sync    = r_sw_sync;
    assign sw_changed = r_sw_chg;
    assign gpio_out   = r_gpio;
    assign busy       = (r_state != StIdle);
    assign hex0       = r_hex[0];
    assign hex1       = r_hex[1];
    assign hex2       = r_hex[2];
    assign hex3       = r_hex[3];
    assign hex4       = r_hex[4];
    assign hex5       = r_hex[5];
    assign hex6       = r_hex[6];
    assign hex7       = r_hex[7];

endmodule

// File: tb/tb_gpio_disp_ctrl.sv
// Self-checking bench for gpio_disp_ctrl: directed and randomized writes against a
// digit-level display model, plus switch synchronizer timing.
module tb_gpio_disp_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        blank_en;
    logic [17:0] sw_in;
    logic [17:0] sw_sync;
    logic        sw_changed;
    logic [31:0] gpio_out;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        busy;
    logic [55:0] w_disp;

    gpio_disp_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .blank_en   (blank_en),
        .sw_in      (sw_in),
        .sw_sync    (sw_sync),
        .sw_changed (sw_changed),
        .gpio_out   (gpio_out),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5),
        .hex6       (hex6),
        .hex7       (hex7),
        .busy       (busy)
    );

    assign w_disp = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [55:0] DISP_RST = {8{7'h40}};

    int          n_checks;
    int          n_fail;
    logic [31:0] m_gpio;
    logic [55:0] m_disp;
    logic [17:0] m_sw;
    logic [8:0]  inj_mask;
    logic [31:0] inj_d [9];
    logic        inj_b [9];

    // Digit i is blank when blanking is on, i>0, and the value shifted down by i digits is zero.
    function automatic logic [55:0] exp_disp(input logic [31:0] d, input logic b);
        logic [55:0] r;
        logic [31:0] hi;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            hi = d >> (4 * i);
            r[i*7 +: 7] = (b && i > 0 && hi == 32'd0) ? 7'h7F : GLYPH[hi[3:0]];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; injections at slot k hit edge E(k+1).
    task automatic run_write(input logic [31:0] d, input logic b);
        logic [31:0] cur_d, nxt_d;
        logic        cur_b, nxt_b, have;
        wr_en = 1'b1; wr_data = d; blank_en = b;
        @(negedge clk);
        cur_d = d; cur_b = b;
        do begin
            have = 1'b0; nxt_d = '0; nxt_b = 1'b0;
            for (int k = 0; k < 9; k++) begin
                check("busy_during_op", 64'(busy), 64'(1'b1));
                check("gpio_hold", 64'(gpio_out), 64'(m_gpio));
                check("disp_hold", 64'(w_disp), 64'(m_disp));
                if (inj_mask[k]) begin
                    wr_en = 1'b1; wr_data = inj_d[k]; blank_en = inj_b[k];
                    have = 1'b1; nxt_d = inj_d[k]; nxt_b = inj_b[k];
                end else begin
                    wr_en = 1'b0;
                end
                @(negedge clk);
            end
            wr_en = 1'b0;
            m_gpio = cur_d;
            m_disp = exp_disp(cur_d, cur_b);
            check("gpio_commit", 64'(gpio_out), 64'(m_gpio));
            check("disp_commit", 64'(w_disp), 64'(m_disp));
            check("busy_after_commit", 64'(busy), 64'(have));
            cur_d = nxt_d; cur_b = nxt_b; inj_mask = '0;
        end while (have);
    endtask

    task automatic sw_change(input logic [17:0] v);
        logic [17:0] old;
        old = m_sw;
        sw_in = v;
        @(negedge clk);
        check("sw_sync_1edge", 64'(sw_sync), 64'(old));
        check("sw_chg_1edge", 64'(sw_changed), 64'(1'b0));
        @(negedge clk);
        check("sw_sync_2edge", 64'(sw_sync), 64'(v));
        check("sw_chg_2edge", 64'(sw_changed), 64'(1'b0));
        @(negedge clk);
        check("sw_chg_pulse", 64'(sw_changed), 64'(v != old));
        @(negedge clk);
        check("sw_chg_end", 64'(sw_changed), 64'(1'b0));
        m_sw = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int          sh;
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; blank_en = 1'b0; sw_in = '0;
        m_gpio = '0; m_disp = DISP_RST; m_sw = '0; inj_mask = '0;
        for (int i = 0; i < 9; i++) begin inj_d[i] = '0; inj_b[i] = 1'b0; end
        repeat (2) @(negedge clk);
        check("rst_gpio", 64'(gpio_out), 64'(32'h0));
        check("rst_disp", 64'(w_disp), 64'(DISP_RST));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_sw_sync", 64'(sw_sync), 64'(18'h0));
        check("rst_sw_chg", 64'(sw_changed), 64'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);

        run_write(32'h00184135, 1'b0);
        check("req18_disp", 64'(w_disp),
              64'({7'h40, 7'h40, 7'h79, 7'h00, 7'h19, 7'h79, 7'h30, 7'h12}));
        run_write(32'h00184135, 1'b1);
        check("req19_blank", 64'(w_disp),
              64'({7'h7F, 7'h7F, 7'h79, 7'h00, 7'h19, 7'h79, 7'h30, 7'h12}));
        run_write(32'h00000000, 1'b1);
        check("req19_zero", 64'(w_disp), 64'({{7{7'h7F}}, 7'h40}));

        inj_mask = 9'b0_0010_0100;
        inj_d[2] = 32'h11111111; inj_b[2] = 1'b0;
        inj_d[5] = 32'h22222222; inj_b[5] = 1'b0;
        run_write(32'h0000000A, 1'b0);
        check("req20_final", 64'(w_disp), 64'({8{7'h24}}));
        check("req20_gpio", 64'(gpio_out), 64'(32'h22222222));

        inj_mask = 9'b1_0000_0000;
        inj_d[8] = 32'h0000BEEF; inj_b[8] = 1'b1;
        run_write(32'h12345678, 1'b0);

        sw_change(18'h2D687);
        repeat (5) begin
            @(negedge clk);
            check("sw_stable", 64'(sw_changed), 64'(1'b0));
        end
        sw_change(18'h2D687);
        sw_change(18'h00001);

        fork
            run_write(32'hCAFE0042, 1'b1);
            sw_change(18'h3FFFF);
        join

        wr_en = 1'b1; wr_data = 32'hDEADBEEF; blank_en = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop_rst_gpio", 64'(gpio_out), 64'(32'h0));
        check("midop_rst_disp", 64'(w_disp), 64'(DISP_RST));
        check("midop_rst_busy", 64'(busy), 64'(1'b0));
        check("midop_rst_sw", 64'(sw_sync), 64'(18'h0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_gpio", 64'(gpio_out), 64'(32'h0));
        check("post_rst_disp", 64'(w_disp), 64'(DISP_RST));
        check("post_rst_busy", 64'(busy), 64'(1'b0));
        check("post_rst_sw", 64'(sw_sync), 64'(m_sw));
        m_gpio = '0; m_disp = DISP_RST;

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_write(32'h0000F00D, 1'b1);

        for (int n = 0; n < 30; n++) begin
            rd = $urandom;
            sh = $urandom_range(0, 8);
            rd = (sh == 8) ? 32'h0 : (rd >> (4 * sh));
            if ($urandom_range(0, 2) == 0) begin
                inj_mask = 9'($urandom);
                for (int k = 0; k < 9; k++) begin
                    inj_d[k] = $urandom >> (4 * $urandom_range(0, 7));
                    inj_b[k] = 1'($urandom_range(0, 1));
                end
            end
            run_write(rd, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_disp_ctrl.md
GPIO_DISP_CTRL -- requirements
Module: gpio_disp_ctrl

Interface
REQ-001 The block SHALL have these ports, in order, as name, direction, width and meaning:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  CPU GPIO write strobe; one write per high cycle.
- wr_data  input  32  CPU GPIO write value (8 packed hex/BCD nibbles).
- blank_en  input  1  leading-zero suppression enable, sampled with wr_en.
- sw_in  input  18  raw board switches, asynchronous to clk.
- sw_sync  output  18  synchronized switch value for the CPU GPIO input.
- sw_changed  output  1  one-cycle pulse when sw_sync changes.
- gpio_out  output  32  last committed write value.
- hex0..hex7  output  7 each  active-low segment drive (bit6=g ... bit0=a); hex0 is the least-significant nibble.
- busy  output  1  high while a write is being processed.

REQ-002 Reset SHALL be asynchronous and active-low on rst_n; all other behaviour SHALL be synchronous to clk.

Function
REQ-003 The FSM SHALL have three states: IDLE, SCAN and COMMIT.
REQ-004 In IDLE, wr_en=1 at clock edge E0 SHALL latch wr_data and blank_en, set the digit index to 7, and enter SCAN.
REQ-005 SCAN SHALL decode one nibble per cycle, index 7 down to 0, at edges E1..E8 into shadow registers, then enter COMMIT.
REQ-006 At E9, COMMIT SHALL copy the shadow registers to hex0..hex7, load gpio_out with the latched value, and enter IDLE (or SCAN per REQ-011).
- Write-to-display latency SHALL be exactly 9 cycles after E0.
REQ-007 busy SHALL be 1 after E0 through E9 and SHALL be 0 in IDLE.
REQ-008 The nibble decode SHALL be standard active-low hex glyphs:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
REQ-009 When the latched blank_en=1, digit i (i=7..1) SHALL be blanked (7F) if nibble i and all higher nibbles are zero.
- Digit 0 SHALL never be blanked.
REQ-010 hex0..hex7 and gpio_out SHALL change only at COMMIT; no partial update SHALL be visible.
REQ-011 wr_en while busy SHALL be stored in a one-deep pending register (data and blank_en).
- A later write SHALL overwrite the pending entry; the latest write wins.
- At COMMIT with a pending entry: load it, clear pending, and go directly to SCAN with index 7; busy SHALL stay 1.
- wr_en in the COMMIT cycle SHALL also go to pending and be served per the rule above.
REQ-012 wr_en in IDLE SHALL never be dropped.
REQ-013 sw_in SHALL pass through a two-flop synchronizer to give sw_sync.
- sw_changed SHALL be 1 for exactly one cycle, in the cycle after sw_sync differs from its previous registered value.
REQ-014 The switch path SHALL be independent of the FSM and SHALL operate in every state.

Reset
REQ-015 While rst_n=0, regardless of state:
- state=IDLE, busy=0, pending cleared
- gpio_out=00000000, hex0..hex7=40 ("0"), shadow registers=40
- sw_sync=0, synchronizer flops=0, sw_changed=0
REQ-016 Reset asserted mid-SCAN or mid-COMMIT SHALL abandon the operation; no commit SHALL occur after release.
REQ-017 After rst_n rises, the first wr_en SHALL be accepted on the first rising edge.

Verification
REQ-018 Write 00184135, blank_en=0 -> 9 cycles later hex7..hex0 = 40,40,79,00,19,79,30,12; gpio_out=00184135; busy high for exactly 9 cycles.
REQ-019 Same write with blank_en=1 -> hex7=7F, hex6=7F, rest as in REQ-018; write 00000000 with blank_en=1 -> hex7..hex1=7F, hex0=40.
REQ-020 Write 0000000A, then while busy write 11111111 and then 22222222:
- First commit shows 0000000A.
- busy stays high; the second commit shows all hex=24 and gpio_out=22222222.
- 11111111 is never displayed.
REQ-021 Write DEADBEEF, assert rst_n=0 at E4 -> outputs return to reset values; after release with no wr_en, gpio_out stays 00000000.
REQ-022 sw_in changes from 00000 to 2D687:
- sw_sync=2D687 two edges later.
- sw_changed high for one cycle; no pulse while sw_in is stable.
